// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter that serialises read/write transactions into the RAM command stream.
// Optional address-command cache enabled by defining RAM_ARB_ADDR_CACHE_EN.
module ram_port_arbiter #(
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic                   req0_we,
  input  logic [ADDR_SIZE-1:0]   req0_addr,
  input  logic [MEM_WIDTH-1:0]   req0_wdata,
  output logic                   req0_ready,
  output logic                   rsp0_valid,
  output logic [MEM_WIDTH-1:0]   rsp0_rdata,
  input  logic                   req1_valid,
  input  logic                   req1_we,
  input  logic [ADDR_SIZE-1:0]   req1_addr,
  input  logic [MEM_WIDTH-1:0]   req1_wdata,
  output logic                   req1_ready,
  output logic                   rsp1_valid,
  output logic [MEM_WIDTH-1:0]   rsp1_rdata,
  output logic [MEM_WIDTH+1:0]   ram_din,
  output logic                   ram_rx_valid,
  input  logic                   ram_tx_valid,
  input  logic [MEM_WIDTH-1:0]   ram_dout,
  output logic                   busy,
  output logic                   grant_id
);

  localparam int CMD_W = MEM_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RD, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CMD_W-1:0]       ram_din_q, ram_din_d;
  logic                   ram_rx_valid_q, ram_rx_valid_d;
  logic                   rsp0_valid_q, rsp0_valid_d;
  logic                   rsp1_valid_q, rsp1_valid_d;
  logic [MEM_WIDTH-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [MEM_WIDTH-1:0]   rsp1_rdata_q, rsp1_rdata_d;
  logic                   grant_id_q, grant_id_d;
  logic                   last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;

  logic                   grant_sel;
  logic                   accept;
  logic                   sel_we;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [MEM_WIDTH-1:0]   sel_wdata;
  logic                   addr_hit;

  function automatic logic [CMD_W-1:0] addr_cmd(input logic we, input logic [ADDR_SIZE-1:0] a);
    logic [MEM_WIDTH-1:0] ext;
    ext = '0;
    ext[ADDR_SIZE-1:0] = a;
    return {(we ? 2'b00 : 2'b10), ext};
  endfunction

  function automatic logic [CMD_W-1:0] data_cmd(input logic we, input logic [MEM_WIDTH-1:0] d);
    return we ? {2'b01, d} : {2'b11, {MEM_WIDTH{1'b0}}};
  endfunction

  // On a tie the port that did not win last time gets the grant.
  assign grant_sel  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_sel;
  assign req1_ready = accept && grant_sel;

  assign sel_we    = grant_sel ? req1_we    : req0_we;
  assign sel_addr  = grant_sel ? req1_addr  : req0_addr;
  assign sel_wdata = grant_sel ? req1_wdata : req0_wdata;

`ifdef RAM_ARB_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] wr_addr_shadow_q, wr_addr_shadow_d;
  logic [ADDR_SIZE-1:0] rd_addr_shadow_q, rd_addr_shadow_d;
  logic                 wr_shadow_ok_q, wr_shadow_ok_d;
  logic                 rd_shadow_ok_q, rd_shadow_ok_d;

  // Write and read address registers in the RAM are independent, so each has its own shadow.
  assign addr_hit = sel_we ? (wr_shadow_ok_q && (wr_addr_shadow_q == sel_addr))
                           : (rd_shadow_ok_q && (rd_addr_shadow_q == sel_addr));

  always_comb begin
    wr_addr_shadow_d = wr_addr_shadow_q;
    rd_addr_shadow_d = rd_addr_shadow_q;
    wr_shadow_ok_d   = wr_shadow_ok_q;
    rd_shadow_ok_d   = rd_shadow_ok_q;
    if (accept && !addr_hit) begin
      if (sel_we) begin
        wr_addr_shadow_d = sel_addr;
        wr_shadow_ok_d   = 1'b1;
      end else begin
        rd_addr_shadow_d = sel_addr;
        rd_shadow_ok_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_shadow_ok_q <= 1'b0;
      rd_shadow_ok_q <= 1'b0;
    end else begin
      wr_shadow_ok_q <= wr_shadow_ok_d;
      rd_shadow_ok_q <= rd_shadow_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_shadow_q <= wr_addr_shadow_d;
    rd_addr_shadow_q <= rd_addr_shadow_d;
  end
`else
  assign addr_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    ram_din_d      = '0;
    ram_rx_valid_d = 1'b0;
    rsp0_valid_d   = 1'b0;
    rsp1_valid_d   = 1'b0;
    rsp0_rdata_d   = rsp0_rdata_q;
    rsp1_rdata_d   = rsp1_rdata_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d           = sel_we;
          wdata_d        = sel_wdata;
          grant_id_d     = grant_sel;
          last_grant_d   = grant_sel;
          ram_rx_valid_d = 1'b1;
          if (addr_hit) begin
            state_d   = DATA;
            ram_din_d = data_cmd(sel_we, sel_wdata);
          end else begin
            state_d   = ADDR;
            ram_din_d = addr_cmd(sel_we, sel_addr);
          end
        end
      end
      ADDR: begin
        state_d        = DATA;
        ram_rx_valid_d = 1'b1;
        ram_din_d      = data_cmd(we_q, wdata_q);
      end
      DATA: begin
        state_d = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          state_d = RESP;
          if (grant_id_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_rdata_d = ram_dout;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_rdata_d = ram_dout;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp0_rdata_q   <= '0;
      rsp1_rdata_q   <= '0;
      grant_id_q     <= 1'b0;
      last_grant_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp1_valid_q   <= rsp1_valid_d;
      rsp0_rdata_q   <= rsp0_rdata_d;
      rsp1_rdata_q   <= rsp1_rdata_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
    end
  end

  // Transaction payload needs no reset: it is only read after an accept reloads it.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp0_rdata   = rsp0_rdata_q;
  assign rsp1_rdata   = rsp1_rdata_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: transaction-level reference model plus a behavioural RAM.
module tb_ram_port_arbiter;
  localparam int MW   = 8;
  localparam int AW   = 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [MW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [MW-1:0] req1_wdata, rsp1_rdata;
  logic [MW+1:0] ram_din;
  logic          ram_rx_valid, ram_tx_valid, busy, grant_id;
  logic [MW-1:0] ram_dout;

  ram_port_arbiter #(.MEM_WIDTH(MW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_tx_valid(ram_tx_valid),
    .ram_dout(ram_dout), .busy(busy), .grant_id(grant_id)
  );

  int total = 0;
  int bad   = 0;
  int cur_c = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cur_c, act, exp);
    end
  endtask

  // Reference state: memory contents, expected command schedule, pending response.
  logic [7:0] ref_mem [256];
  logic [7:0] ram_mem [256];
  logic [7:0] stub_wa, stub_ra;
  logic       exp_rx_v [NCYC+16];
  logic [9:0] exp_din  [NCYC+16];
  logic [7:0] exp_rdata [2];
  int         free_c, tx_c, wait_lo, wait_hi, rsp_c, rsp_p;
  logic [7:0] rsp_d;
  logic       last_g, gid, prev_rst;
  logic       wok, rok;
  logic [7:0] wsh, rsh;

  logic       rv [2], rwe [2], rdir [2], hs [2], e_rdy [2];
  logic [7:0] ra [2], rd [2];
  logic [16:0] dq0 [$];
  logic [16:0] dq1 [$];

  task automatic new_req(input int p);
    logic [16:0] e;
    if (p == 0 && dq0.size() > 0) begin
      e = dq0.pop_front();
      rdir[p] = 1'b1; rv[p] = 1'b1; rwe[p] = e[16]; ra[p] = e[15:8]; rd[p] = e[7:0];
    end else if (p == 1 && dq1.size() > 0) begin
      e = dq1.pop_front();
      rdir[p] = 1'b1; rv[p] = 1'b1; rwe[p] = e[16]; ra[p] = e[15:8]; rd[p] = e[7:0];
    end else if ($urandom_range(0, 2) != 0) begin
      rdir[p] = 1'b0; rv[p] = 1'b1; rwe[p] = 1'($urandom);
      ra[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      rd[p] = 8'($urandom);
    end
  endtask

  task automatic model_accept(input int c, input int p);
    logic skip;
    int   dcy;
    gid    = p[0];
    last_g = p[0];
    skip   = 1'b0;
`ifdef RAM_ARB_ADDR_CACHE_EN
    skip = rwe[p] ? (wok && wsh == ra[p]) : (rok && rsh == ra[p]);
    if (!skip) begin
      if (rwe[p]) begin wok = 1'b1; wsh = ra[p]; end
      else begin rok = 1'b1; rsh = ra[p]; end
    end
`endif
    if (!skip) begin
      exp_rx_v[c+1] = 1'b1;
      exp_din[c+1]  = {(rwe[p] ? 2'b00 : 2'b10), ra[p]};
    end
    dcy = skip ? c + 1 : c + 2;
    exp_rx_v[dcy] = 1'b1;
    exp_din[dcy]  = rwe[p] ? {2'b01, rd[p]} : 10'h300;
    if (rwe[p]) begin
      ref_mem[ra[p]] = rd[p];
      free_c = dcy + 1;
    end else begin
      tx_c    = dcy + 1 + int'($urandom_range(0, 3));
      wait_lo = dcy + 1;
      wait_hi = tx_c;
      rsp_c   = tx_c + 1;
      rsp_p   = p;
      rsp_d   = ref_mem[ra[p]];
      free_c  = tx_c + 2;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      ram_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < NCYC + 16; i++) begin
      exp_rx_v[i] = 1'b0;
      exp_din[i]  = '0;
    end
    stub_wa = '0; stub_ra = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    free_c = 0; tx_c = -1; wait_lo = -1; wait_hi = -2; rsp_c = -1; rsp_p = 0; rsp_d = '0;
    last_g = 1'b1; gid = 1'b0; prev_rst = 1'b0;
    wok = 1'b0; rok = 1'b0; wsh = '0; rsh = '0;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; rwe[p] = 1'b0; rdir[p] = 1'b0; hs[p] = 1'b0; e_rdy[p] = 1'b0;
      ra[p] = '0; rd[p] = '0;
    end
    // Directed sequences: write/read-back, tied reads, repeated write address.
    dq0.push_back({1'b1, 8'h12, 8'hA5});
    dq0.push_back({1'b0, 8'h12, 8'h00});
    dq0.push_back({1'b1, 8'h40, 8'h11});
    dq0.push_back({1'b1, 8'h40, 8'h22});
    dq0.push_back({1'b1, 8'h41, 8'h33});
    dq1.push_back({1'b0, 8'h12, 8'h00});
    dq1.push_back({1'b0, 8'h12, 8'h00});
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    ram_tx_valid = 1'b1; ram_dout = '0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cur_c = c;
      if (c < 3) rst_n = 1'b0;
      else if ((c >= wait_lo && c <= wait_hi && $urandom_range(0, 5) == 0) ||
               (c >= free_c && $urandom_range(0, 99) == 0)) rst_n = 1'b0;
      else rst_n = 1'b1;

      for (int p = 0; p < 2; p++) begin
        if (c < 3) begin
          rv[p] = 1'b1; rdir[p] = 1'b0; rwe[p] = 1'($urandom);
          ra[p] = 8'($urandom_range(0, 7)); rd[p] = 8'($urandom);
        end else if (hs[p]) begin
          rv[p] = 1'b0;
          new_req(p);
        end else if (rv[p] && !rdir[p] && $urandom_range(0, 9) == 0) begin
          rv[p] = 1'b0;
        end else if (!rv[p]) begin
          new_req(p);
        end
      end
      req0_valid = rv[0]; req0_we = rwe[0]; req0_addr = ra[0]; req0_wdata = rd[0];
      req1_valid = rv[1]; req1_we = rwe[1]; req1_addr = ra[1]; req1_wdata = rd[1];

      if (c < 3) begin
        ram_tx_valid = 1'b1; ram_dout = 8'($urandom);
      end else if (c == tx_c) begin
        ram_tx_valid = 1'b1; ram_dout = ram_mem[stub_ra];
      end else if (c >= wait_lo && c <= wait_hi) begin
        ram_tx_valid = 1'b0; ram_dout = 8'($urandom);
      end else begin
        ram_tx_valid = ($urandom_range(0, 3) == 0); ram_dout = 8'($urandom);
      end

      @(negedge clk);
      if (c == rsp_c) exp_rdata[rsp_p] = rsp_d;
      for (int p = 0; p < 2; p++)
        e_rdy[p] = rst_n && (c >= free_c) && rv[p] && (!rv[1-p] || last_g != p[0]);
      if (c >= 1) begin
        chk("req0_ready", 32'(req0_ready), 32'(e_rdy[0]));
        chk("req1_ready", 32'(req1_ready), 32'(e_rdy[1]));
        chk("busy", 32'(busy), 32'(c < free_c));
        chk("grant_id", 32'(grant_id), 32'(gid));
        chk("rx_valid", 32'(ram_rx_valid), 32'(exp_rx_v[c]));
        if (exp_rx_v[c]) chk("ram_din", 32'(ram_din), 32'(exp_din[c]));
        if (prev_rst) chk("din_after_rst", 32'(ram_din), 32'h0);
        chk("rsp0_valid", 32'(rsp0_valid), 32'(c == rsp_c && rsp_p == 0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(c == rsp_c && rsp_p == 1));
        chk("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_rdata[0]));
        chk("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_rdata[1]));
      end

      hs[0] = e_rdy[0];
      hs[1] = e_rdy[1];
      if (e_rdy[0]) model_accept(c, 0);
      else if (e_rdy[1]) model_accept(c, 1);

      // Behavioural RAM decodes whatever the DUT actually sends.
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00: stub_wa = ram_din[7:0];
          2'b01: ram_mem[stub_wa] = ram_din[7:0];
          2'b10: stub_ra = ram_din[7:0];
          default: ;
        endcase
      end

      if (!rst_n) begin
        free_c = c + 1; last_g = 1'b1; gid = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        if (rsp_c > c) rsp_c = -1;
        if (tx_c > c) tx_c = -1;
        wait_lo = -1; wait_hi = -2;
        wok = 1'b0; rok = 1'b0;
      end
      prev_rst = !rst_n;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
